fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the rv32 in-order core. It owns the PC, issues one-outstanding requests to instruction memory, and buffers returned words, absorbing stall with a one-entry skid buffer. It presents the instruction, its PC, and pre-decoded immediate fields (`id_base_imm`, `id_imm_src`) that feed the decode-stage immediate sign-extender directly. Flushes redirect the PC and discard all in-flight or buffered instructions.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage plus IF/ID pipeline register for the rv32 in-order
// core. It owns the PC and keeps at most one instruction-memory request in
// flight. Returned words land in the ID slot, or in a one-entry skid buffer
// when decode is stalled. A flush redirects the PC and throws away anything
// fetched or still in flight.
//
// Ports
//   clock, reset       : rising-edge clock, async active-low reset
//   imem_req_*         : request channel (valid/ready, addr == pc)
//   imem_resp_*        : response channel (one word per accepted request)
//   stall              : decode cannot take the ID slot this cycle
//   flush/flush_target : redirect to a new word-aligned PC
//   id_*               : ID slot contents plus pre-decoded immediate fields
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [24:0] id_base_imm,
   output logic [1:0]  id_imm_src
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   entry_t      id_q, id_d;
   entry_t      skid_q, skid_d;
   logic        req_vld_q, req_vld_d;

   logic   accept, consume, slot_free, resp_ok;
   entry_t resp_e;

   // Target LSBs are ignored: the PC is always word aligned.
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = ^flush_target[1:0];

   always_comb begin
      accept    = req_vld_q && imem_req_ready;
      consume   = id_q.valid && !stall;
      slot_free = !id_q.valid || consume;
      resp_ok   = (state_q == S_WAIT) && imem_resp_valid;

      resp_e.valid = 1'b1;
      resp_e.instr = imem_resp_data;
      resp_e.pc    = req_pc_q;

      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      id_d     = id_q;
      skid_d   = skid_q;

      if (flush) begin
         id_d.valid   = 1'b0;
         skid_d.valid = 1'b0;
         pc_d         = {flush_target[31:2], 2'b00};
         // A request still owed a response (already outstanding, or being
         // accepted right now) must have that response swallowed in DROP.
         if (accept ||
             ((state_q == S_WAIT) && !imem_resp_valid) ||
             ((state_q == S_DROP) && !imem_resp_valid))
            state_d = S_DROP;
         else
            state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (accept) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT:  if (imem_resp_valid) state_d = S_FETCH;
            S_DROP:  if (imem_resp_valid) state_d = S_FETCH;
            default: state_d = S_FETCH;
         endcase

         // The skid entry is always older than a response arriving now, so
         // it drains first and the new word takes its place.
         if (skid_q.valid && slot_free) begin
            id_d         = skid_q;
            skid_d.valid = 1'b0;
            if (resp_ok) skid_d = resp_e;
         end else if (resp_ok) begin
            if (slot_free) id_d = resp_e;
            else           skid_d = resp_e;
         end else if (consume) begin
            id_d.valid = 1'b0;
         end
      end

      // Next-cycle request valid is decided from next state only, so the
      // output never depends combinationally on stall/flush/ready.
      req_vld_d = (state_d == S_FETCH) && !skid_d.valid;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         req_pc_q  <= '0;
         id_q      <= '0;
         skid_q    <= '0;
         req_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         id_q      <= id_d;
         skid_q    <= skid_d;
         req_vld_q <= req_vld_d;
      end
   end

   assign imem_req_valid = req_vld_q;
   assign imem_req_addr  = pc_q;

   assign id_valid    = id_q.valid;
   assign id_instr    = id_q.instr;
   assign id_pc       = id_q.pc;
   assign id_pc_plus4 = id_q.pc + 32'd4;
   assign id_base_imm = id_q.instr[31:7];

   // Immediate format for the decode sign-extender: S=01, B=10, J=11,
   // everything else treated as I-type.
   always_comb begin
      case (id_q.instr[6:0])
         7'b0100011: id_imm_src = 2'b01;
         7'b1100011: id_imm_src = 2'b10;
         7'b1101111: id_imm_src = 2'b11;
         default:    id_imm_src = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural memory answers each
// accepted request after a fixed or random latency. Directed scenario tasks
// cover reset, first fetch, stall/skid, flushes, decode and PC wrap; a random
// task checks the delivered instruction stream against a PC-sequence model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_target = '0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [24:0] id_base_imm;
   logic [1:0]  id_imm_src;

   always #5 clock = ~clock;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .stall(stall), .flush(flush), .flush_target(flush_target),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4), .id_base_imm(id_base_imm),
      .id_imm_src(id_imm_src)
   );

   int n_chk = 0;
   int n_fail = 0;

   // memory model controls
   int          mem_lat = 1;        // 0 = random 1..3
   bit          mem_ready_rand = 0;
   bit          mem_fixed_en = 0;
   logic [31:0] mem_fixed = '0;
   bit          pend = 0;
   int          cnt = 0;
   logic [31:0] pdata = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      logic [6:0]  op;
      if (mem_fixed_en) return mem_fixed;
      h = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
      case (a[5:4])
         2'd0:    op = 7'b0100011;
         2'd1:    op = 7'b1100011;
         2'd2:    op = 7'b1101111;
         default: op = 7'b0010011;
      endcase
      return {h[31:7], op};
   endfunction

   function automatic logic [1:0] exp_src(input logic [31:0] w);
      case (w[6:0])
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   // Memory: inputs change on the falling edge, so the DUT sees them stable
   // for the following rising edge.
   always @(negedge clock) begin
      if (!reset) begin
         pend            = 0;
         imem_resp_valid = 1'b0;
         imem_req_ready  = 1'b1;
      end else begin
         imem_resp_valid = 1'b0;
         if (pend && cnt == 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pdata;
            pend            = 0;
         end else if (pend) begin
            cnt = cnt - 1;
         end
         imem_req_ready = mem_ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (imem_req_valid && imem_req_ready) begin
            pend  = 1;
            cnt   = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            pdata = mem_word(imem_req_addr);
         end
      end
   end

   // Advance to the sampling point of the next cycle (just after negedge).
   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
      n_chk++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_id_instr: got %h expected 0", id_instr); end
      n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
      n_chk++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", imem_req_addr, RST_PC); end
   endtask

   task automatic test_first_fetch();
      mem_fixed_en = 1; mem_fixed = 32'h00500093; mem_lat = 1; stall = 1'b0;
      reset = 1'b1;
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      n_chk++;
      if (!(imem_req_valid && imem_req_ready) || imem_req_addr !== 32'h100) begin
         n_fail++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=00000100", imem_req_valid, imem_req_addr);
      end
      step(); step();
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL first_id: got v=%b pc=%h expected v=1 pc=00000100", id_valid, id_pc); end
      n_chk++; if (id_instr !== 32'h00500093) begin n_fail++; $display("FAIL first_instr: got %h expected 00500093", id_instr); end
      n_chk++; if (id_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL first_plus4: got %h expected 00000104", id_pc_plus4); end
      n_chk++; if (id_base_imm !== 25'h00A001) begin n_fail++; $display("FAIL first_base_imm: got %h expected 00a001", id_base_imm); end
      n_chk++; if (id_imm_src !== 2'b00) begin n_fail++; $display("FAIL first_imm_src: got %b expected 00", id_imm_src); end
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      n_chk++;
      if (!(imem_req_valid && imem_req_ready) || imem_req_addr !== 32'h104) begin
         n_fail++; $display("FAIL second_req: got v=%b a=%h expected v=1 a=00000104", imem_req_valid, imem_req_addr);
      end
      mem_fixed_en = 0;
   endtask

   task automatic test_stall_skid();
      int nreq;
      logic [31:0] a0, a1;
      nreq = 0; a0 = '0; a1 = '0;
      mem_lat = 1;
      stall = 1'b1; flush = 1'b1; flush_target = 32'h104;
      step();
      flush = 1'b0;
      for (int t = 0; t < 12; t++) begin
         if (imem_req_valid && imem_req_ready) begin
            if (nreq == 0) a0 = imem_req_addr; else a1 = imem_req_addr;
            nreq++;
         end
         step();
      end
      n_chk++; if (nreq != 2) begin n_fail++; $display("FAIL stall_req_count: got %0d expected 2", nreq); end
      n_chk++; if (a0 !== 32'h104 || a1 !== 32'h108) begin n_fail++; $display("FAIL stall_req_addrs: got %h %h expected 00000104 00000108", a0, a1); end
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h104) begin n_fail++; $display("FAIL stall_id_hold: got v=%b pc=%h expected v=1 pc=00000104", id_valid, id_pc); end
      n_chk++; if (id_instr !== mem_word(32'h104)) begin n_fail++; $display("FAIL stall_id_instr: got %h expected %h", id_instr, mem_word(32'h104)); end
      n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_third_req: got %b expected 0", imem_req_valid); end
      stall = 1'b0;
      step();
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin n_fail++; $display("FAIL skid_drain: got v=%b pc=%h expected v=1 pc=00000108", id_valid, id_pc); end
      n_chk++; if (id_instr !== mem_word(32'h108)) begin n_fail++; $display("FAIL skid_instr: got %h expected %h", id_instr, mem_word(32'h108)); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10C) begin n_fail++; $display("FAIL req_resume: got v=%b a=%h expected v=1 a=0000010c", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_flush_wait();
      bit got_req;
      logic [31:0] ra;
      got_req = 0; ra = '0;
      stall = 1'b0; mem_lat = 3;
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      step();
      flush = 1'b1; flush_target = 32'h2002;
      step();
      flush = 1'b0;
      for (int t = 0; t < 25 && !id_valid; t++) begin
         if (imem_req_valid && imem_req_ready && !got_req) begin got_req = 1; ra = imem_req_addr; end
         step();
      end
      n_chk++; if (!got_req || ra !== 32'h2000) begin n_fail++; $display("FAIL flush_wait_req: got seen=%b a=%h expected seen=1 a=00002000", got_req, ra); end
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h2000) begin n_fail++; $display("FAIL flush_wait_id: got v=%b pc=%h expected v=1 pc=00002000", id_valid, id_pc); end
      mem_lat = 1;
   endtask

   task automatic test_flush_resp_stall();
      mem_lat = 1;
      stall = 1'b1; flush = 1'b1; flush_target = 32'h3000;
      step();
      flush = 1'b0;
      for (int t = 0; t < 15 && !(imem_resp_valid && id_valid); t++) step();
      n_chk++; if (!(imem_resp_valid && id_valid)) begin n_fail++; $display("FAIL frs_setup: got resp=%b idv=%b expected 1 1", imem_resp_valid, id_valid); end
      flush = 1'b1; flush_target = 32'h4000;
      step();
      flush = 1'b0;
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL frs_id_clear: got %b expected 0", id_valid); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4000) begin n_fail++; $display("FAIL frs_fetch: got v=%b a=%h expected v=1 a=00004000", imem_req_valid, imem_req_addr); end
      for (int t = 0; t < 10 && !id_valid; t++) step();
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h4000) begin n_fail++; $display("FAIL frs_next_id: got v=%b pc=%h expected v=1 pc=00004000", id_valid, id_pc); end
      stall = 1'b0;
   endtask

   task automatic test_decode_sweep();
      logic [31:0] words [4];
      logic [1:0]  srcs  [4];
      logic [31:0] tgt;
      logic [31:0] w;
      words[0] = 32'hfe000ee3; srcs[0] = 2'b10;
      words[1] = 32'h00112623; srcs[1] = 2'b01;
      words[2] = 32'h008000ef; srcs[2] = 2'b11;
      words[3] = 32'h00c58533; srcs[3] = 2'b00;
      stall = 1'b0; mem_lat = 1; mem_fixed_en = 1;
      for (int i = 0; i < 4; i++) begin
         mem_fixed = words[i];
         w = words[i];
         tgt = 32'h5000 + 32'(i) * 32'h100;
         flush = 1'b1; flush_target = tgt;
         step();
         flush = 1'b0;
         for (int t = 0; t < 20 && !(id_valid && id_pc == tgt); t++) step();
         n_chk++; if (id_valid !== 1'b1 || id_instr !== w) begin n_fail++; $display("FAIL decode_instr[%0d]: got v=%b %h expected v=1 %h", i, id_valid, id_instr, w); end
         n_chk++; if (id_imm_src !== srcs[i]) begin n_fail++; $display("FAIL decode_src[%0d]: got %b expected %b", i, id_imm_src, srcs[i]); end
         n_chk++; if (id_base_imm !== w[31:7]) begin n_fail++; $display("FAIL decode_base[%0d]: got %h expected %h", i, id_base_imm, w[31:7]); end
      end
      mem_fixed_en = 0;
   endtask

   task automatic test_wrap_reset();
      stall = 1'b0; mem_lat = 3;
      flush = 1'b1; flush_target = 32'hFFFF_FFFE;
      step();
      flush = 1'b0;
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      n_chk++; if (!(imem_req_valid && imem_req_ready) || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got v=%b a=%h expected v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
      step();
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      n_chk++; if (!(imem_req_valid && imem_req_ready) || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); end
      step();  // now waiting on the 0x0 response
      reset = 1'b0;
      #1;
      n_chk++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valids: got req=%b id=%b expected 0 0", imem_req_valid, id_valid); end
      n_chk++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_payload: got %h %h expected 0 0", id_instr, id_pc); end
      n_chk++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL mid_rst_pc: got %h expected %h", imem_req_addr, RST_PC); end
      step(); step();
      mem_lat = 1;
      reset = 1'b1;
      for (int t = 0; t < 10 && !(imem_req_valid && imem_req_ready); t++) step();
      n_chk++; if (!(imem_req_valid && imem_req_ready) || imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL post_rst_req: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC); end
   endtask

   // Random stall/flush/latency/ready; the model is just the expected PC of
   // the next request and of the next instruction decode consumes.
   task automatic test_random();
      logic [31:0] exp_req, exp_id, tgt, w;
      bit fl;
      int n_cons;
      n_cons = 0;
      mem_ready_rand = 1; mem_lat = 0; mem_fixed_en = 0;
      tgt = $urandom;
      stall = 1'b0; flush = 1'b1; flush_target = tgt;
      step();
      flush = 1'b0;
      exp_req = {tgt[31:2], 2'b00};
      exp_id  = exp_req;
      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom_range(0, 1) == 1);
         fl    = ($urandom_range(0, 31) == 0);
         tgt   = $urandom;
         flush = fl; flush_target = tgt;
         if (imem_req_valid) begin
            n_chk++;
            if (imem_req_addr !== exp_req) begin n_fail++; $display("FAIL rnd_req_addr cyc %0d: got %h expected %h", c, imem_req_addr, exp_req); end
            if (imem_req_ready && !fl) exp_req = exp_req + 32'd4;
         end
         if (id_valid && !stall && !fl) begin
            w = mem_word(exp_id);
            n_chk++;
            if (id_pc !== exp_id || id_instr !== w || id_pc_plus4 !== exp_id + 32'd4 ||
                id_base_imm !== w[31:7] || id_imm_src !== exp_src(w)) begin
               n_fail++;
               $display("FAIL rnd_consume cyc %0d: got pc=%h i=%h p4=%h src=%b expected pc=%h i=%h src=%b",
                        c, id_pc, id_instr, id_pc_plus4, id_imm_src, exp_id, w, exp_src(w));
            end
            exp_id = exp_id + 32'd4;
            n_cons++;
         end
         if (fl) begin
            exp_req = {tgt[31:2], 2'b00};
            exp_id  = exp_req;
         end
         step();
      end
      flush = 1'b0; stall = 1'b0;
      n_chk++; if (n_cons < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed expected >= 200", n_cons); end
      mem_ready_rand = 0; mem_lat = 1;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall_skid();
      test_flush_wait();
      test_flush_resp_stall();
      test_decode_sweep();
      test_wrap_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
